// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: synchronizes A/B, optionally glitch-filters them, and
// emits step/direction pulses. The glitch filter is built only with QUAD_GLITCH_FILTER_EN.
module quad_step_decoder #(
  parameter int FILT_LEN    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic step,
  output logic upordown,
  output logic err_pulse,
  output logic err_sticky
);

  if (FILT_LEN < 2 || FILT_LEN > 16) begin : g_filt_len_chk
    $error("FILT_LEN must be in 2..16");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_sync_chk
    $error("SYNC_STAGES must be in 2..4");
  end

  // Position of a state along the forward cycle 00->01->11->10.
  function automatic logic [1:0] gray_pos(input logic [1:0] v);
    logic [1:0] p;
    case (v)
      2'b00:   p = 2'd0;
      2'b01:   p = 2'd1;
      2'b11:   p = 2'd2;
      default: p = 2'd3;
    endcase
    return p;
  endfunction

  // p0: input synchronizers
  logic [SYNC_STAGES-1:0] a_sync_p0;
  logic [SYNC_STAGES-1:0] b_sync_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sync_p0 <= '0;
      b_sync_p0 <= '0;
    end else begin
      a_sync_p0 <= {a_sync_p0[SYNC_STAGES-2:0], a_in};
      b_sync_p0 <= {b_sync_p0[SYNC_STAGES-2:0], b_in};
    end
  end

  // p1: acceptance of the synchronized value
  logic [1:0] s_p1;
  logic       acc_vld_p1;

  assign s_p1 = {a_sync_p0[SYNC_STAGES-1], b_sync_p0[SYNC_STAGES-1]};

`ifdef QUAD_GLITCH_FILTER_EN
  localparam logic [3:0] CNT_MAX = 4'(FILT_LEN - 1);
  localparam logic [3:0] CNT_ACC = 4'(FILT_LEN - 2);

  logic [1:0] cand_p1;
  logic [3:0] filt_cnt;

  // cand_p1 is the value being qualified; the cycle it first appears counts as sample one.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand_p1  <= 2'b00;
      filt_cnt <= 4'd0;
    end else if (s_p1 != cand_p1) begin
      cand_p1  <= s_p1;
      filt_cnt <= 4'd0;
    end else if (filt_cnt != CNT_MAX) begin
      filt_cnt <= filt_cnt + 4'd1;
    end
  end

  assign acc_vld_p1 = (s_p1 == cand_p1) && (filt_cnt >= CNT_ACC);
`else
  assign acc_vld_p1 = 1'b1;
`endif

  // p2: transition decode against the accepted state
  logic [1:0] ab_p2;
  logic       init_p2;
  logic       is_up;
  logic       is_dn;
  logic       is_ill;
  logic [1:0] delta;

  always_comb begin
    is_up  = 1'b0;
    is_dn  = 1'b0;
    is_ill = 1'b0;
    delta  = gray_pos(s_p1) - gray_pos(ab_p2);
    if (acc_vld_p1 && !init_p2) begin
      case (delta)
        2'd1:    is_up  = 1'b1;
        2'd3:    is_dn  = 1'b1;
        2'd2:    is_ill = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ab_p2      <= 2'b00;
      init_p2    <= 1'b1;
      step       <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
      upordown   <= 1'b1;
    end else begin
      step      <= is_up | is_dn;
      err_pulse <= is_ill;
      if (is_up) begin
        upordown <= 1'b1;
      end else if (is_dn) begin
        upordown <= 1'b0;
      end
      if (acc_vld_p1) begin
        ab_p2   <= s_p1;
        init_p2 <= 1'b0;
      end
      if (is_ill) begin
        err_sticky <= 1'b1;
      end else if (err_clr) begin
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Bench for quad_step_decoder: cycle-level reference model plus directed scenarios.
// Honours QUAD_GLITCH_FILTER_EN the same way the design does.
module tb_quad_step_decoder;

  localparam int FILT_LEN    = 4;
  localparam int SYNC_STAGES = 2;
`ifdef QUAD_GLITCH_FILTER_EN
  localparam int LAT     = SYNC_STAGES + FILT_LEN;
  localparam int RST_ERR = 0;
`else
  localparam int LAT     = SYNC_STAGES + 1;
  localparam int RST_ERR = 1;
`endif

  logic clk = 1'b0;
  logic reset, a_in, b_in, err_clr;
  logic step, upordown, err_pulse, err_sticky;

  quad_step_decoder #(.FILT_LEN(FILT_LEN), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .err_clr(err_clr),
    .step(step), .upordown(upordown), .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int step_cnt = 0;
  int err_cnt  = 0;
  int last_step_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  // Position in the forward sequence, found by searching the sequence itself.
  function automatic int seq_pos(input logic [1:0] v);
    logic [1:0] fwd [4];
    fwd = '{2'b00, 2'b01, 2'b11, 2'b10};
    for (int i = 0; i < 4; i++) if (fwd[i] == v) return i;
    return 0;
  endfunction

  // Reference model state
  logic [1:0] syncq[$];
  logic [1:0] m_ab, last_s, s;
  logic m_init, m_step, m_err, m_sticky, m_ud, acc, ill;
  int run, d;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      syncq.delete();
      for (int i = 0; i < SYNC_STAGES; i++) syncq.push_back(2'b00);
      run = 1; last_s = 2'b00;
      m_ab = 2'b00; m_init = 1'b1; m_step = 1'b0; m_err = 1'b0;
      m_sticky = 1'b0; m_ud = 1'b1;
    end else begin
      s = syncq[0];
      void'(syncq.pop_front());
      syncq.push_back({a_in, b_in});
      if (s == last_s) begin
        if (run < 1000) run++;
      end else begin
        run = 1; last_s = s;
      end
`ifdef QUAD_GLITCH_FILTER_EN
      acc = (run >= FILT_LEN);
`else
      acc = 1'b1;
`endif
      m_step = 1'b0; ill = 1'b0;
      if (acc) begin
        if (!m_init) begin
          d = (seq_pos(s) - seq_pos(m_ab) + 4) % 4;
          if (d == 1) begin m_step = 1'b1; m_ud = 1'b1; end
          if (d == 3) begin m_step = 1'b1; m_ud = 1'b0; end
          if (d == 2) ill = 1'b1;
        end
        m_ab = s; m_init = 1'b0;
      end
      m_err = ill;
      m_sticky = ill ? 1'b1 : (err_clr ? 1'b0 : m_sticky);
    end
    #1;
    chk("step", int'(step), int'(m_step));
    chk("upordown", int'(upordown), int'(m_ud));
    chk("err_pulse", int'(err_pulse), int'(m_err));
    chk("err_sticky", int'(err_sticky), int'(m_sticky));
    if (step === 1'b1) begin step_cnt++; last_step_cyc = cyc; end
    if (err_pulse === 1'b1) err_cnt++;
  end

  task automatic hold(input logic [1:0] v, input int n);
    {a_in, b_in} = v;
    repeat (n) @(negedge clk);
  endtask

  int s0, e0, dc;

  initial begin
    reset = 1'b1; a_in = 1'b0; b_in = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_step", int'(step), 0);
    chk("rst_err", int'(err_pulse), 0);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_ud", int'(upordown), 1);
    reset = 1'b0;

    s0 = step_cnt;
    hold(2'b00, SYNC_STAGES + FILT_LEN + 2);
    chk("idle_steps", step_cnt - s0, 0);
    chk("idle_ud", int'(upordown), 1);
    chk("idle_sticky", int'(err_sticky), 0);

    s0 = step_cnt; dc = cyc;
    hold(2'b01, 10);
    chk("latency", last_step_cyc, dc + LAT);
    hold(2'b11, 10); hold(2'b10, 10); hold(2'b00, 10);
    chk("fwd_steps", step_cnt - s0, 4);
    chk("fwd_ud", int'(upordown), 1);

    s0 = step_cnt;
    hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10); hold(2'b00, 10);
    chk("rev_steps", step_cnt - s0, 4);
    chk("rev_ud", int'(upordown), 0);

    s0 = step_cnt; e0 = err_cnt;
    hold(2'b11, 10);
    chk("ill_err", err_cnt - e0, 1);
    chk("ill_steps", step_cnt - s0, 0);
    chk("ill_sticky", int'(err_sticky), 1);
    chk("ill_ud", int'(upordown), 0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    chk("clr_sticky", int'(err_sticky), 0);

    e0 = err_cnt; err_clr = 1'b1;
    hold(2'b00, 10);
    err_clr = 1'b0;
    chk("setwin_err", err_cnt - e0, 1);
    chk("setwin_sticky", int'(err_sticky), 0);

`ifdef QUAD_GLITCH_FILTER_EN
    s0 = step_cnt;
    hold(2'b01, 3); hold(2'b00, 10);
    chk("glitch3_steps", step_cnt - s0, 0);
    s0 = step_cnt;
    hold(2'b01, 4); hold(2'b00, 4);
    chk("glitch4_steps", step_cnt - s0, 1);
    chk("glitch4_ud", int'(upordown), 1);
    hold(2'b00, 6);
    chk("glitch4_back", step_cnt - s0, 2);
`else
    s0 = step_cnt;
    hold(2'b01, 1); hold(2'b00, 10);
    chk("glitch1_steps", step_cnt - s0, 2);
    chk("glitch1_ud", int'(upordown), 0);
`endif

    hold(2'b11, 10);
    chk("pre_rst_sticky", int'(err_sticky), 1);
    reset = 1'b1; @(negedge clk); reset = 1'b0;
    chk("mid_rst_step", int'(step), 0);
    chk("mid_rst_ud", int'(upordown), 1);
    chk("mid_rst_sticky", int'(err_sticky), 0);
    s0 = step_cnt; e0 = err_cnt;
    hold(2'b11, 15);
    chk("reload_steps", step_cnt - s0, 0);
    chk("reload_err", err_cnt - e0, RST_ERR);
    s0 = step_cnt;
    hold(2'b01, 10);
    chk("after_reload_steps", step_cnt - s0, 1);
    chk("after_reload_ud", int'(upordown), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
